// File: rtl/expye_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : expye_cpu_core
// Description : Five-stage (IF/ID/EX/MEM/WB) 32-bit pipelined core running a
//               MIPS32 integer ALU subset from a 128-word instruction ROM.
//               All operand hazards are resolved by forwarding into ID, so
//               the pipeline never stalls. Results live in the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module expye_cpu_core (
    input  logic clk,
    input  logic rst
);

    localparam int c_ROM_WORDS = 128;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_t;

    // Instruction image ("inst_rom.data", one hex word per line) is placed
    // here at time zero by the loading environment; unloaded words are 0.
    logic [31:0] r_rom [0:c_ROM_WORDS-1];

    // Architectural register file
    logic [31:0] regs [0:31];

    // Fetch state
    logic [8:0]  r_pc;
    logic [31:0] r_ifid_instr;

    // ID/EX
    alu_op_t     r_idex_op;
    logic [31:0] r_idex_a;
    logic [31:0] r_idex_b;
    logic        r_idex_we;
    logic [4:0]  r_idex_rd;

    // EX/MEM
    logic        r_exmem_we;
    logic [4:0]  r_exmem_rd;
    logic [31:0] r_exmem_data;

    // MEM/WB
    logic        r_memwb_we;
    logic [4:0]  r_memwb_rd;
    logic [31:0] r_memwb_data;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_opcode = r_ifid_instr[31:26];
    assign w_rs     = r_ifid_instr[25:21];
    assign w_rt     = r_ifid_instr[20:16];
    assign w_rd     = r_ifid_instr[15:11];
    assign w_shamt  = r_ifid_instr[10:6];
    assign w_funct  = r_ifid_instr[5:0];
    assign w_imm    = r_ifid_instr[15:0];

    logic [31:0] w_ex_result;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    alu_op_t     w_dec_op;
    logic [31:0] w_dec_a;
    logic [31:0] w_dec_b;
    logic        w_dec_we;
    logic [4:0]  w_dec_rd;

    // Youngest producer wins: EX, then MEM, then WB bypass, then the array.
    // Register $0 never forwards because it can never hold a value.
    function automatic logic [31:0] fwd(input logic [4:0] idx);
        if (idx == 5'd0)                             return 32'h0;
        else if (r_idex_we  && (r_idex_rd  == idx))  return w_ex_result;
        else if (r_exmem_we && (r_exmem_rd == idx))  return r_exmem_data;
        else if (r_memwb_we && (r_memwb_rd == idx))  return r_memwb_data;
        else                                         return regs[idx];
    endfunction

    // Fetch: PC advances every cycle and wraps within the 512-byte ROM
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc         <= 9'd0;
            r_ifid_instr <= 32'h0;
        end else begin
            r_pc         <= r_pc + 9'd4;
            r_ifid_instr <= r_rom[r_pc[8:2]];
        end
    end

    // Forwarded source operands for the instruction in ID
    always_comb begin
        w_rs_val = fwd(w_rs);
        w_rt_val = fwd(w_rt);
    end

    // Decode into ALU op, operands and destination; unknown encodings write nothing
    always_comb begin
        w_dec_op = ALU_OR;
        w_dec_a  = w_rs_val;
        w_dec_b  = w_rt_val;
        w_dec_we = 1'b0;
        w_dec_rd = w_rt;
        case (w_opcode)
            6'h00: begin
                w_dec_rd = w_rd;
                w_dec_we = 1'b1;
                case (w_funct)
                    6'h21: w_dec_op = ALU_ADD;
                    6'h23: w_dec_op = ALU_SUB;
                    6'h24: w_dec_op = ALU_AND;
                    6'h25: w_dec_op = ALU_OR;
                    6'h26: w_dec_op = ALU_XOR;
                    6'h27: w_dec_op = ALU_NOR;
                    6'h00, 6'h02, 6'h03: begin
                        // Shifts operate on rt; the shift amount rides in b
                        w_dec_a = w_rt_val;
                        w_dec_b = {27'h0, w_shamt};
                        if (w_funct == 6'h00)      w_dec_op = ALU_SLL;
                        else if (w_funct == 6'h02) w_dec_op = ALU_SRL;
                        else                       w_dec_op = ALU_SRA;
                    end
                    default: w_dec_we = 1'b0;
                endcase
            end
            6'h09: begin
                w_dec_op = ALU_ADD;
                w_dec_b  = {{16{w_imm[15]}}, w_imm};
                w_dec_we = 1'b1;
            end
            6'h0C: begin
                w_dec_op = ALU_AND;
                w_dec_b  = {16'h0, w_imm};
                w_dec_we = 1'b1;
            end
            6'h0D: begin
                w_dec_op = ALU_OR;
                w_dec_b  = {16'h0, w_imm};
                w_dec_we = 1'b1;
            end
            6'h0E: begin
                w_dec_op = ALU_XOR;
                w_dec_b  = {16'h0, w_imm};
                w_dec_we = 1'b1;
            end
            6'h0F: begin
                // LUI is an OR of the shifted immediate with zero
                w_dec_op = ALU_OR;
                w_dec_a  = 32'h0;
                w_dec_b  = {w_imm, 16'h0};
                w_dec_we = 1'b1;
            end
            default: w_dec_we = 1'b0;
        endcase
    end

    // EX-stage ALU
    always_comb begin
        w_ex_result = 32'h0;
        case (r_idex_op)
            ALU_ADD: w_ex_result = r_idex_a + r_idex_b;
            ALU_SUB: w_ex_result = r_idex_a - r_idex_b;
            ALU_AND: w_ex_result = r_idex_a & r_idex_b;
            ALU_OR:  w_ex_result = r_idex_a | r_idex_b;
            ALU_XOR: w_ex_result = r_idex_a ^ r_idex_b;
            ALU_NOR: w_ex_result = ~(r_idex_a | r_idex_b);
            ALU_SLL: w_ex_result = r_idex_a << r_idex_b[4:0];
            ALU_SRL: w_ex_result = r_idex_a >> r_idex_b[4:0];
            ALU_SRA: w_ex_result = $signed(r_idex_a) >>> r_idex_b[4:0];
            default: w_ex_result = 32'h0;
        endcase
    end

    // ID/EX, EX/MEM and MEM/WB pipeline registers; reset squashes to bubbles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idex_op    <= ALU_OR;
            r_idex_a     <= 32'h0;
            r_idex_b     <= 32'h0;
            r_idex_we    <= 1'b0;
            r_idex_rd    <= 5'd0;
            r_exmem_we   <= 1'b0;
            r_exmem_rd   <= 5'd0;
            r_exmem_data <= 32'h0;
            r_memwb_we   <= 1'b0;
            r_memwb_rd   <= 5'd0;
            r_memwb_data <= 32'h0;
        end else begin
            r_idex_op    <= w_dec_op;
            r_idex_a     <= w_dec_a;
            r_idex_b     <= w_dec_b;
            r_idex_we    <= w_dec_we;
            r_idex_rd    <= w_dec_rd;
            r_exmem_we   <= r_idex_we;
            r_exmem_rd   <= r_idex_rd;
            r_exmem_data <= w_ex_result;
            r_memwb_we   <= r_exmem_we;
            r_memwb_rd   <= r_exmem_rd;
            r_memwb_data <= r_exmem_data;
        end
    end

    // Writeback into the register file; $0 is never written
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (r_memwb_we && (r_memwb_rd != 5'd0)) begin
            regs[r_memwb_rd] <= r_memwb_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expye_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_expye_cpu_core
// Description : Directed bench for expye_cpu_core. Programs are placed in the
//               core ROM; expected register-file writes are queued with the
//               edge at which they must appear and compared as edges elapse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expye_cpu_core;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    expye_cpu_core dut (
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        int          edge_n;
        int          r;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_push(input int e, input int r, input logic [31:0] v);
        exp_t x;
        x.edge_n = e;
        x.r      = r;
        x.v      = v;
        sb.push_back(x);
    endtask

    task automatic load_rom();
        for (int i = 0; i < 128; i++)
            dut.r_rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
    endtask

    // Hold reset for one edge, confirm everything is cleared, then release
    task automatic do_reset(input string tag);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_pc"}, {23'h0, dut.r_pc}, 32'h0);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", tag, i), dut.regs[i], 32'h0);
        rst = 1'b1;
        cyc = 0;
    endtask

    // One edge; retire every scoreboard entry due at this edge
    task automatic step();
        exp_t x;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].edge_n == cyc) begin
            x = sb.pop_front();
            check($sformatf("e%0d_r%0d", cyc, x.r), dut.regs[x.r], x.v);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
        if (sb.size() != 0) begin
            check("sb_drain", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic push_wrap();
        exp_push(4, 1, 32'h0);
        exp_push(5, 1, 32'hFFFF0000);
        exp_push(6, 1, 32'hFFFFFFFF);
        exp_push(7, 2, 32'h00000000);
        exp_push(7, 3, 32'h0);
        exp_push(8, 3, 32'h00000001);
        exp_push(8, 4, 32'h0);
        exp_push(9, 4, 32'hFFFFFFFF);
    endtask

    task automatic push_zero_illegal();
        exp_push(5, 0, 32'h0);
        exp_push(5, 2, 32'h0);
        exp_push(6, 1, 32'h0);
        for (int r = 0; r < 32; r++) exp_push(7, r, 32'h0);
        exp_push(8, 2, 32'h00000007);
    endtask

    initial begin
        // Single ORI, then let the PC wrap around the ROM
        prog = {32'h34011100};
        load_rom();
        do_reset("t1_rst");
        exp_push(4, 1, 32'h0);
        exp_push(5, 1, 32'h00001100);
        run(8);
        for (int i = 0; i < 32; i++)
            check($sformatf("t1_r%0d", i), dut.regs[i], (i == 1) ? 32'h00001100 : 32'h0);
        check("t1_pc8", {23'h0, dut.r_pc}, 32'd32);
        run(120);
        check("t1_pc_wrap", {23'h0, dut.r_pc}, 32'd0);
        check("t1_r1_after_wrap", dut.regs[1], 32'h00001100);

        // Back-to-back dependent chain, no NOPs
        prog = {32'h34010020, 32'h34224400, 32'h00221825, 32'h00612026};
        load_rom();
        do_reset("t2_rst");
        exp_push(4, 1, 32'h0);
        exp_push(5, 1, 32'h00000020);
        exp_push(5, 2, 32'h0);
        exp_push(6, 2, 32'h00004420);
        exp_push(6, 3, 32'h0);
        exp_push(7, 3, 32'h00004420);
        exp_push(7, 4, 32'h0);
        exp_push(8, 4, 32'h00004400);
        run(10);

        // Shifts of a negative value
        prog = {32'h3C018000, 32'h00011103, 32'h00011902, 32'h00012040};
        load_rom();
        do_reset("t3_rst");
        exp_push(5, 1, 32'h80000000);
        exp_push(5, 2, 32'h0);
        exp_push(6, 2, 32'hF8000000);
        exp_push(6, 3, 32'h0);
        exp_push(7, 3, 32'h08000000);
        exp_push(8, 4, 32'h00000000);
        run(10);

        // Modulo-2^32 arithmetic, then a reset that squashes in-flight work
        prog = {32'h3C01FFFF, 32'h3421FFFF, 32'h24220001, 32'h00011823, 32'h00002027};
        load_rom();
        do_reset("t4_rst");
        push_wrap();
        run(10);
        check("t4_r2_final", dut.regs[2], 32'h0);
        do_reset("t4_rst2");
        exp_push(5, 1, 32'hFFFF0000);
        exp_push(6, 1, 32'hFFFFFFFF);
        run(6);
        do_reset("t4_squash");
        push_wrap();
        run(10);

        // $0 is immutable, illegal opcode writes nothing
        prog = {32'h34000005, 32'h00000825, 32'hFC000000, 32'h34020007};
        load_rom();
        do_reset("t5_rst");
        push_zero_illegal();
        run(12);

        // Reset after 12 cycles of the same program, then identical replay
        do_reset("t6_midrun");
        push_zero_illegal();
        run(12);
        check("t6_r2_final", dut.regs[2], 32'h00000007);
        check("t6_r0_final", dut.regs[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/expye_cpu_core.md
# expye_cpu_core

Single-issue, 5-stage (IF/ID/EX/MEM/WB) pipelined 32-bit processor executing a MIPS32 integer ALU subset from an internal instruction ROM. It is the top-level compute block of the design: it has only clock and reset pins, and all results are observed through its internal register file. The pipeline resolves all data hazards by forwarding, so it never stalls.

## Interface
- Parameters: none. The ROM is 128 words. The image file is "inst_rom.data" (hex, one word per line), loaded at time zero.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-low (rst=0 resets on the next rising edge).

## Operation
- **PC**
  - Increments by 4 each cycle.
  - ROM is word-addressed by pc[8:2]; the PC wraps at 512 bytes.
  - ROM words not loaded from the image read as 0x00000000 (NOP).
- **Register file**
  - 32 x 32-bit array, internal name `regs`.
  - $0 always reads 0; writes to $0 are discarded.
  - Two combinational read ports and one write port, written at the WB clock edge.
  - Same-cycle WB-to-ID bypass: a read of the register being written returns the new value.
- **I-type** (rt = result; rs = source; imm = instr[15:0]):
  - ADDIU 0x09: rs + signext(imm), mod 2^32.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extend imm.
  - LUI 0x0F: {imm, 16'h0}.
- **R-type** (opcode 0x00, rd = result):
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - ADDU 0x21, SUBU 0x23: mod 2^32, no overflow trap.
  - SLL 0x00, SRL 0x02, SRA 0x03: shift rt by shamt = instr[10:6].
- **Unsupported opcodes/functs:** treated as NOP (no register write).
- **Forwarding priority for rs/rt in ID:**
  1. EX-stage result, if its write enable is set and its destination is nonzero and matches;
  2. else MEM-stage result;
  3. else register file (which includes the WB bypass).
- **MEM stage:** pass-through. No data memory and no branches in this block.
- **Pipeline registers:** each carries write enable, 5-bit destination and 32-bit data (plus decoded ALU operation and operands where needed).

## Timing
- **Reset:**
  - PC = 0.
  - All pipeline registers are cleared to a bubble (write enable 0, data 0).
  - All 32 registers are cleared to 0.
- **Startup:** at the first rising edge with rst=1, IF/ID captures rom[0] and PC becomes 4.
- **Writeback latency:** instruction k (0-based) writes the register file at rising edge k+5 after rst deasserts. The result is readable immediately after that edge.
- **Throughput:** one instruction per cycle, with no stalls, including back-to-back dependent instructions.
- **Reset mid-run:** takes effect at the next edge. All in-flight instructions are squashed (no partial writeback), the register file is cleared, and execution restarts from address 0.

## Test plan
- ROM[0]=0x34011100 (ori $1,$0,0x1100) -> $1 = 0x00001100 after edge 5; all other registers stay 0.
- Dependent chain with no NOPs: ori $1,$0,0x0020; ori $2,$1,0x4400; or $3,$1,$2; xor $4,$3,$1 -> $2=0x00004420, $3=0x00004420, $4=0x00004400, written at edges 6, 7 and 8.
- Shifts: lui $1,0x8000; sra $2,$1,4; srl $3,$1,4; sll $4,$1,1 -> $2=0xF8000000, $3=0x08000000, $4=0x00000000.
- Wrap arithmetic: lui $1,0xFFFF; ori $1,$1,0xFFFF; addiu $2,$1,1; subu $3,$0,$1; nor $4,$0,$0 -> $1=0xFFFFFFFF, $2=0, $3=1, $4=0xFFFFFFFF.
- $0 and illegal-opcode handling:
  - ori $0,$0,5; or $1,$0,$0; illegal word 0xFC000000; ori $2,$0,7 -> $0=0 and $1=0.
  - No register changes when the illegal word reaches WB.
  - $2=7.
- Reset mid-run: run the previous program 12 cycles, then hold rst=0 for one edge -> all registers and PC read 0 after that edge. After release, identical results appear at the same relative edges.
